// File: rtl/demux3w_1to5.sv
// demux3w_1to5: routes a data word into one of five registered channels
// (U..Y). It tracks per-channel valid flags and a frame FSM that pulses
// FrameDone when all five channels have been written.
// Reset is synchronous and active-low (Resetn).
// Optional feature macro: DEMUX_AUTOSEQ_EN adds Auto/Ptr round-robin addressing.
// The data-width parameter is called WIDTH because the name W is taken
// by the third channel output.
//
// state | meaning
// IDLE  | no channel valid (Vld == 0)
// FILL  | some, but not all, channels valid
// FULL  | all five channels valid (Vld == 5'b11111)
module demux3w_1to5 #(
  parameter int WIDTH = 3
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [WIDTH-1:0] D,
  input  logic [2:0]       S,
  input  logic             Load,
  input  logic             Clear,
`ifdef DEMUX_AUTOSEQ_EN
  input  logic             Auto,
  output logic [2:0]       Ptr,
`endif
  output logic [WIDTH-1:0] U,
  output logic [WIDTH-1:0] V,
  output logic [WIDTH-1:0] W,
  output logic [WIDTH-1:0] X,
  output logic [WIDTH-1:0] Y,
  output logic [4:0]       Vld,
  output logic             Full,
  output logic             FrameDone,
  output logic             Err
);

  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

  state_t     state, state_nxt;
  logic [2:0] sel;
  logic       legal;
  logic       wr;
  logic [4:0] vld_nxt;
  logic       err_nxt;
  logic       done_nxt;

  // Channel selection, write qualification, next Vld/Err, and next FSM state
  always_comb begin
    sel       = S;
    legal     = (S <= 3'd4);
`ifdef DEMUX_AUTOSEQ_EN
    if (Auto) begin
      sel   = Ptr;
      legal = 1'b1;
    end
`endif
    wr        = Load && legal && !Clear;
    vld_nxt   = Vld;
    err_nxt   = Err;
    state_nxt = state;
    if (Clear) begin
      vld_nxt   = 5'b00000;
      err_nxt   = 1'b0;
      state_nxt = IDLE;
    end else if (Load) begin
      if (legal) begin
        for (int i = 0; i < 5; i++) begin
          if (sel == 3'(i)) vld_nxt[i] = 1'b1;
        end
      end else begin
        err_nxt = 1'b1;
      end
      case (state)
        IDLE:    if (legal) state_nxt = (vld_nxt == 5'b11111) ? FULL : FILL;
        FILL:    if (vld_nxt == 5'b11111) state_nxt = FULL;
        FULL:    state_nxt = FULL;
        default: state_nxt = IDLE;
      endcase
    end
    done_nxt = (state_nxt == FULL) && (state != FULL);
  end

  // Frame FSM, valid flags, sticky error and completion pulse
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state     <= IDLE;
      Vld       <= 5'b00000;
      Err       <= 1'b0;
      FrameDone <= 1'b0;
    end else begin
      state     <= state_nxt;
      Vld       <= vld_nxt;
      Err       <= err_nxt;
      FrameDone <= done_nxt;
    end
  end

  // Channel data registers; Clear leaves them untouched
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      U <= '0;
      V <= '0;
      W <= '0;
      X <= '0;
      Y <= '0;
    end else if (wr) begin
      case (sel)
        3'd0:    U <= D;
        3'd1:    V <= D;
        3'd2:    W <= D;
        3'd3:    X <= D;
        3'd4:    Y <= D;
        default: ;
      endcase
    end
  end

`ifdef DEMUX_AUTOSEQ_EN
  // Round-robin write pointer, advances only on auto-sequenced loads
  always_ff @(posedge Clock) begin
    if (!Resetn || Clear) begin
      Ptr <= 3'd0;
    end else if (Auto && Load) begin
      Ptr <= (Ptr == 3'd4) ? 3'd0 : Ptr + 3'd1;
    end
  end
`endif

  assign Full = (state == FULL);

endmodule

// File: doc/demux3w_1to5.md
DEMUX3W_1TO5 -- requirements
Module: demux3w_1to5

Interface
REQ-001 Parameter: W, default 3, data width of input D and of each channel output.
REQ-002 Clock  in  1  rising-edge clock; sole clock.
REQ-003 Resetn  in  1  reset, synchronous and active-low.
REQ-004 D  in  W  data word to distribute.
REQ-005 S  in  3  channel select; 0..4 address U, V, W, X, Y in that order; 5..7 illegal.
REQ-006 Load  in  1  write strobe, sampled each rising edge.
REQ-007 Clear  in  1  synchronous frame clear.
REQ-008 U, V, W, X, Y  out  W each  registered channel data.
REQ-009 Vld  out  5  per-channel valid flags; bit 0 = U ... bit 4 = Y.
REQ-010 Full  out  1  high while all five channels are valid.
REQ-011 FrameDone  out  1  one-cycle pulse when the frame completes.
REQ-012 Err  out  1  sticky illegal-select flag.

Function
REQ-013 Load=1 and S in 0..4 on an edge SHALL write D into channel S and set Vld[S]; output visible 1 cycle after the edge.
REQ-014 Load=1 and S in 5..7 SHALL write no channel, leave Vld unchanged, and set Err.
REQ-015 Load=0 SHALL hold all channel registers, Vld, and Err.
REQ-016 A write to an already-valid channel SHALL overwrite its data; Vld unchanged; no FrameDone.
REQ-017 The frame FSM SHALL have states IDLE (Vld=0), FILL (Vld nonzero, not all ones), and FULL (Vld=5'b11111).
REQ-018 Transitions SHALL be: IDLE->FILL on first legal write; FILL->FULL on the write that sets the last clear Vld bit; any state->IDLE on Clear; FULL remains FULL on further writes.
REQ-019 Full SHALL equal (state==FULL).
REQ-020 FrameDone SHALL pulse high for exactly the cycle in which the FSM first enters FULL.
REQ-021 Clear=1 SHALL zero Vld and Err and move the FSM to IDLE; channel data SHALL be retained.
REQ-022 Clear=1 and Load=1 on the same edge: Clear wins; the write is ignored.
REQ-023 Err SHALL stay high until Clear or reset, regardless of later legal writes.

Reset
REQ-024 Resetn=0 at an edge SHALL set U..Y=0, Vld=0, Full=0, FrameDone=0, Err=0, FSM=IDLE; this overrides Load and Clear.
REQ-025 Reset asserted mid-frame SHALL discard partial frame state; no FrameDone SHALL be issued.

Configuration
REQ-026 Macro DEMUX_AUTOSEQ_EN, when defined, SHALL add input Auto (1 bit) and output Ptr (3 bits).
REQ-027 With DEMUX_AUTOSEQ_EN defined and Auto=1: S is ignored, each Load writes channel Ptr, and Ptr increments 0,1,2,3,4,0 (wraps 4->0); Err cannot be set.
REQ-028 Ptr SHALL reset to 0 on Resetn=0 and on Clear; Ptr SHALL hold when Auto=0 or Load=0.
REQ-029 With DEMUX_AUTOSEQ_EN undefined, Auto and Ptr SHALL not exist and S SHALL always select the channel.

Verification
REQ-030 Reset, then Load with S=0..4 and D=1..5 on consecutive cycles -> U..Y=1..5; Vld steps 00001..11111; FrameDone is high only in the cycle after the S=4 write; Full=1.
REQ-031 Load S=6, D=7 -> no channel changes, Vld unchanged, Err=1; a later legal write leaves Err=1; Clear -> Err=0, Vld=0, data retained.
REQ-032 Write S=2 twice (D=3, then D=6) -> W=6, Vld=00100, no FrameDone; Clear and Load on the same edge -> Vld=0, no write.
REQ-033 Fill four channels, assert Resetn=0 for one edge -> all outputs 0, FSM IDLE, no FrameDone; refill all five -> exactly one FrameDone.
REQ-034 DEMUX_AUTOSEQ_EN defined, Auto=1, 6 Loads with D=1..6 -> U=6, V..Y=2..5, Ptr=1, FrameDone after the 5th Load, Err=0.
